// File: rtl/ahb_regfile_subordinate.sv
// AHB-Lite register-file responder with byte-lane writes, programmable wait states
// and the two-cycle ERROR response, for exercising manager-side HREADY/HRESP handling.
module ahb_regfile_subordinate #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 512,
    parameter int WAIT_WRITE   = 0,
    parameter int WAIT_READ    = 0
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    input  logic                  i_hsel,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hreadyin,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DATA_WIDTH-1:0] o_hrdata
);

    localparam int         IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [3:0] N_WR  = 4'(WAIT_WRITE);
    localparam logic [3:0] N_RD  = 4'(WAIT_READ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [1:0]              off_q, off_d;
    logic [1:0]              size_q, size_d;
    logic                    write_q, write_d;
    logic                    hready_q, hready_d;
    logic                    hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEMORY_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_word_d;
    logic [3:0]              lane_en;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    accept;
    logic                    acc_err;
    logic [3:0]              acc_wait;
    logic                    unused_htrans;

    assign unused_htrans = i_htrans[0];
    assign word_addr     = i_haddr >> 2;

    // A new address phase is only taken when the previous data phase is finishing.
    assign accept   = (state_q inside {S_IDLE, S_DATA, S_ERR2}) & i_hsel & i_hreadyin & i_htrans[1];
    assign acc_wait = i_hwrite ? N_WR : N_RD;

    always_comb begin
        acc_err = 1'b0;
        if (i_hsize > 3'd2)
            acc_err = 1'b1;
        else if ((i_hsize == 3'd1) && i_haddr[0])
            acc_err = 1'b1;
        else if ((i_hsize == 3'd2) && (i_haddr[1:0] != 2'b00))
            acc_err = 1'b1;
        else if (word_addr >= ADDR_WIDTH'(MEMORY_DEPTH))
            acc_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = S_DATA;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = word_addr[IDX_W-1:0];
                    off_d   = i_haddr[1:0];
                    size_d  = i_hsize[1:0];
                    write_d = i_hwrite;
                    if (acc_err) begin
                        state_d = S_ERR1;
                    end else if (acc_wait != 4'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = acc_wait;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
        hready_d = !(state_d inside {S_WAIT, S_ERR1});
        hresp_d  = state_d inside {S_ERR1, S_ERR2};
    end

    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            off_q    <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    lane_en = 4'b0001 << off_q;
            2'd1:    lane_en = off_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
        for (int b = 0; b < 4; b++)
            mem_word_d[8*b +: 8] = lane_en[b] ? i_hwdata[8*b +: 8] : mem_q[idx_q][8*b +: 8];
    end

    // Write data is taken on the edge that closes the DATA cycle.
    assign wr_en = (state_q == S_DATA) && write_q;

    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            for (int i = 0; i < MEMORY_DEPTH; i++)
                mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx_q] <= mem_word_d;
        end
    end

    assign o_hreadyout = hready_q;
    assign o_hresp     = hresp_q;
    assign o_hrdata    = ((state_q == S_DATA) && !write_q) ? mem_q[idx_q] : '0;

endmodule
